// File: rtl/video_timing_pkg.sv
// Shared raster timing constants and helpers for the video timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_PIPE_DELAY = 2;

  localparam int X_W  = 11;
  localparam int Y_W  = 10;
  localparam int FC_W = 16;

  localparam int X_MAX_TOTAL = 1 << X_W;
  localparam int Y_MAX_TOTAL = 1 << Y_W;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_bits_t;

  function automatic int timing_total(input int active, input int fp, input int sync,
                                      input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/video_timing_generator_signal_delay.sv
// Async-reset shift register; DEPTH=0 degenerates to a plain wire.
// Every stage resets to RESET_VAL so the delayed signals start out idle.
module signal_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator: pixel counters, sync/DE generation, and realignment of
// a fixed-latency pixel source's RGB with delayed sync/DE for a TMDS encoder.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic            pixel_clk,
  input  logic            reset,
  output logic [X_W-1:0]  x,
  output logic [Y_W-1:0]  y,
  output logic            active,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count,
  input  logic [7:0]      red_in,
  input  logic [7:0]      green_in,
  input  logic [7:0]      blue_in,
  output logic [7:0]      red,
  output logic [7:0]      green,
  output logic [7:0]      blue,
  output logic            vde,
  output logic            hsync,
  output logic            vsync
);

  localparam int H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

  if (H_TOTAL > X_MAX_TOTAL || V_TOTAL > Y_MAX_TOTAL) begin : g_bad_size
    $error("video_timing_generator: H_TOTAL/V_TOTAL exceed counter width");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
    $error("video_timing_generator: PIPE_DELAY must be 0..15");
  end

  // Comparisons use one extra bit so an end bound equal to 2^W does not alias to 0.
  localparam logic [X_W:0]   X_LAST    = (X_W+1)'(H_TOTAL - 1);
  localparam logic [Y_W:0]   Y_LAST    = (Y_W+1)'(V_TOTAL - 1);
  localparam logic [X_W:0]   X_ACT     = (X_W+1)'(H_ACTIVE);
  localparam logic [Y_W:0]   Y_ACT     = (Y_W+1)'(V_ACTIVE);
  localparam logic [X_W:0]   X_HS_BEG  = (X_W+1)'(HS_START);
  localparam logic [X_W:0]   X_HS_END  = (X_W+1)'(HS_END);
  localparam logic [Y_W:0]   Y_VS_BEG  = (Y_W+1)'(VS_START);
  localparam logic [Y_W:0]   Y_VS_END  = (Y_W+1)'(VS_END);
  localparam sync_bits_t     DLY_IDLE  = '{de: 1'b0, hs: ~HSYNC_POL, vs: ~VSYNC_POL};

  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [FC_W-1:0] frame_count_q, frame_count_d;
  logic            x_wrap, y_wrap;

  logic [X_W:0]    x_ext;
  logic [Y_W:0]    y_ext;
  logic            de_raw, hs_raw, vs_raw;
  sync_bits_t      raw_bits, dly_bits;

  logic            vde_q, vde_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic [7:0]      red_q, red_d;
  logic [7:0]      green_q, green_d;
  logic [7:0]      blue_q, blue_d;

  always_comb begin
    x_ext         = {1'b0, x_q};
    y_ext         = {1'b0, y_q};
    x_wrap        = (x_ext == X_LAST);
    y_wrap        = (y_ext == Y_LAST);
    x_d           = x_wrap ? '0 : x_q + 1'b1;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    if (x_wrap) begin
      y_d = y_wrap ? '0 : y_q + 1'b1;
      if (y_wrap) begin
        frame_count_d = frame_count_q + 1'b1;
      end
    end
  end

  always_comb begin
    de_raw      = (x_ext < X_ACT) && (y_ext < Y_ACT);
    hs_raw      = (x_ext >= X_HS_BEG) && (x_ext < X_HS_END);
    vs_raw      = (y_ext >= Y_VS_BEG) && (y_ext < Y_VS_END);
    raw_bits.de = de_raw;
    raw_bits.hs = hs_raw ? HSYNC_POL : ~HSYNC_POL;
    raw_bits.vs = vs_raw ? VSYNC_POL : ~VSYNC_POL;
  end

  // Sync bits travel already converted to output polarity so idle stages read as deasserted.
  signal_delay #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (DLY_IDLE)
  ) u_sync_delay (
    .clk  (pixel_clk),
    .rst  (reset),
    .din  (raw_bits),
    .dout (dly_bits)
  );

  always_comb begin
    vde_d   = dly_bits.de;
    hsync_d = dly_bits.hs;
    vsync_d = dly_bits.vs;
    red_d   = dly_bits.de ? red_in   : 8'd0;
    green_d = dly_bits.de ? green_in : 8'd0;
    blue_d  = dly_bits.de ? blue_in  : 8'd0;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      vde_q         <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      vde_q         <= vde_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = frame_count_q;
  assign active      = de_raw;
  assign line_start  = (x_q == '0) && (y_ext < Y_ACT);
  assign frame_start = (x_q == '0) && (y_q == '0);
  assign vde         = vde_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: a default-horizontal / short-vertical instance
// with PIPE_DELAY=2 and a tiny 7x5 instance with PIPE_DELAY=0.
module tb_video_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [10:0] x;
  logic [9:0]  y;
  logic        active, line_start, frame_start;
  logic [15:0] frame_count;
  logic [7:0]  red_in, green_in, blue_in, red, green, blue;
  logic        vde, hsync, vsync;

  logic [10:0] x_s;
  logic [9:0]  y_s;
  logic        active_s, line_start_s, frame_start_s;
  logic [15:0] frame_count_s;
  logic [7:0]  red_in_s, green_in_s, blue_in_s, red_s, green_s, blue_s;
  logic        vde_s, hsync_s, vsync_s;

  video_timing_generator #(
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .pixel_clk(clk), .reset(rst), .x(x), .y(y), .active(active),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(red), .green(green), .blue(blue), .vde(vde), .hsync(hsync), .vsync(vsync)
  );

  video_timing_generator #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DELAY(0)
  ) dut_s (
    .pixel_clk(clk), .reset(rst), .x(x_s), .y(y_s), .active(active_s),
    .line_start(line_start_s), .frame_start(frame_start_s), .frame_count(frame_count_s),
    .red_in(red_in_s), .green_in(green_in_s), .blue_in(blue_in_s),
    .red(red_s), .green(green_s), .blue(blue_s), .vde(vde_s), .hsync(hsync_s), .vsync(vsync_s)
  );

  typedef struct {
    int n;
    int ex;
    int ey;
    bit act;
    bit ls;
    bit fs;
    int fc;
    bit vde;
    bit hs;
    bit vs;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;
  int   vi     = 0;
  int   vde_run, hs_run, vs_run;
  logic [10:0] xh0, xh1, xh2;
  logic [9:0]  yh0, yh1, yh2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s n=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  task automatic add_vec(input int vn, input int ex, input int ey, input bit act, input bit ls,
                         input bit fs, input int fc, input bit ode, input bit ohs, input bit ovs);
    vec_t v;
    v.n = vn; v.ex = ex; v.ey = ey; v.act = act; v.ls = ls; v.fs = fs;
    v.fc = fc; v.vde = ode; v.hs = ohs; v.vs = ovs;
    vecs.push_back(v);
  endtask

  // Reference raster for the main instance: 800 x 12, outputs lag the counters by 3.
  task automatic check_main();
    int mx, my, fc, m, ox, oy;
    bit de, hs, vs, ls, fs, act;
    logic [7:0] er, eg, eb;
    mx  = n % 800;
    my  = (n / 800) % 12;
    fc  = (n / 9600) % 65536;
    act = (mx < 640) && (my < 6);
    ls  = (mx == 0) && (my < 6);
    fs  = (mx == 0) && (my == 0);
    m   = n - 3;
    if (m < 0) begin
      de = 0; hs = 1; vs = 1; er = 0; eg = 0; eb = 0;
    end else begin
      ox = m % 800;
      oy = (m / 800) % 12;
      de = (ox < 640) && (oy < 6);
      hs = !((ox >= 656) && (ox < 752));
      vs = !((oy >= 8) && (oy < 10));
      er = de ? 8'(ox) : 8'd0;
      eg = de ? 8'(oy) : 8'd0;
      eb = de ? ~8'(ox) : 8'd0;
    end
    chk("main_counters", {x, y, frame_count, active, line_start, frame_start},
        {11'(mx), 10'(my), 16'(fc), act, ls, fs});
    chk("main_outputs", {vde, hsync, vsync, red, green, blue}, {de, hs, vs, er, eg, eb});
  endtask

  // Reference raster for the tiny instance: 7 x 5, outputs lag the counters by 1.
  task automatic check_small();
    int sx, sy, fc, m, ox, oy;
    bit de, hs, vs, ls, fs;
    logic [7:0] er, eg, eb;
    sx = n % 7;
    sy = (n / 7) % 5;
    fc = n / 35;
    ls = (sx == 0) && (sy < 2);
    fs = (sx == 0) && (sy == 0);
    m  = n - 1;
    if (m < 0) begin
      de = 0; hs = 1; vs = 1; er = 0; eg = 0; eb = 0;
    end else begin
      ox = m % 7;
      oy = (m / 7) % 5;
      de = (ox < 4) && (oy < 2);
      hs = (ox != 5);
      vs = (oy != 3);
      er = de ? 8'(m * 3) : 8'd0;
      eg = de ? 8'h5A : 8'd0;
      eb = de ? 8'hC3 : 8'd0;
    end
    chk("small_counters", {x_s, y_s, frame_count_s, line_start_s, frame_start_s},
        {11'(sx), 10'(sy), 16'(fc), ls, fs});
    chk("small_outputs", {vde_s, hsync_s, vsync_s, red_s, green_s, blue_s},
        {de, hs, vs, er, eg, eb});
  endtask

  task automatic check_runs();
    if (vde === 1'b1) vde_run++;
    else begin
      if (vde_run > 0) chk("vde_run_len", 64'(vde_run), 64'd640);
      vde_run = 0;
    end
    if (hsync === 1'b0) hs_run++;
    else begin
      if (hs_run > 0) chk("hsync_low_len", 64'(hs_run), 64'd96);
      hs_run = 0;
    end
    if (vsync === 1'b0) vs_run++;
    else begin
      if (vs_run > 0) chk("vsync_low_len", 64'(vs_run), 64'd1600);
      vs_run = 0;
    end
  endtask

  task automatic check_vec();
    if (vi < vecs.size() && vecs[vi].n == n) begin
      chk("vec_timing", {x, y, active, line_start, frame_start, frame_count},
          {11'(vecs[vi].ex), 10'(vecs[vi].ey), vecs[vi].act, vecs[vi].ls, vecs[vi].fs,
           16'(vecs[vi].fc)});
      chk("vec_out", {vde, hsync, vsync}, {vecs[vi].vde, vecs[vi].hs, vecs[vi].vs});
      vi++;
    end
  endtask

  // Source model: pixel data for coordinate (x,y) appears two cycles after it.
  task automatic drive_sources();
    xh2 = xh1; xh1 = xh0; xh0 = x;
    yh2 = yh1; yh1 = yh0; yh0 = y;
    red_in     = xh2[7:0];
    green_in   = yh2[7:0];
    blue_in    = ~xh2[7:0];
    red_in_s   = 8'(n * 3);
    green_in_s = 8'h5A;
    blue_in_s  = 8'hC3;
  endtask

  task automatic restart_state();
    xh0 = '0; xh1 = '0; xh2 = '0;
    yh0 = '0; yh1 = '0; yh2 = '0;
    vde_run = 0; hs_run = 0; vs_run = 0;
  endtask

  // Caller has just released reset on a falling edge; that edge is n=0.
  task automatic run_cycles(input int last, input bit use_table);
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      n = k;
      check_main();
      check_small();
      check_runs();
      if (use_table) check_vec();
      drive_sources();
    end
  endtask

  initial begin
    add_vec(0,    0,   0,  1, 1, 1, 0, 0, 1, 1);
    add_vec(1,    1,   0,  1, 0, 0, 0, 0, 1, 1);
    add_vec(2,    2,   0,  1, 0, 0, 0, 0, 1, 1);
    add_vec(3,    3,   0,  1, 0, 0, 0, 1, 1, 1);
    add_vec(642,  642, 0,  0, 0, 0, 0, 1, 1, 1);
    add_vec(643,  643, 0,  0, 0, 0, 0, 0, 1, 1);
    add_vec(658,  658, 0,  0, 0, 0, 0, 0, 1, 1);
    add_vec(659,  659, 0,  0, 0, 0, 0, 0, 0, 1);
    add_vec(754,  754, 0,  0, 0, 0, 0, 0, 0, 1);
    add_vec(755,  755, 0,  0, 0, 0, 0, 0, 1, 1);
    add_vec(799,  799, 0,  0, 0, 0, 0, 0, 1, 1);
    add_vec(800,  0,   1,  1, 1, 0, 0, 0, 1, 1);
    add_vec(803,  3,   1,  1, 0, 0, 0, 1, 1, 1);
    add_vec(4800, 0,   6,  0, 0, 0, 0, 0, 1, 1);
    add_vec(6403, 3,   8,  0, 0, 0, 0, 0, 1, 0);
    add_vec(8002, 2,   10, 0, 0, 0, 0, 0, 1, 0);
    add_vec(8003, 3,   10, 0, 0, 0, 0, 0, 1, 1);
    add_vec(9599, 799, 11, 0, 0, 0, 0, 0, 1, 1);
    add_vec(9600, 0,   0,  1, 1, 1, 1, 0, 1, 1);
    add_vec(9603, 3,   0,  1, 0, 0, 1, 1, 1, 1);

    rst = 1'b1;
    red_in = '0; green_in = '0; blue_in = '0;
    red_in_s = '0; green_in_s = '0; blue_in_s = '0;
    restart_state();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {vde, hsync, vsync, red, x, y, frame_count},
        {1'b0, 1'b1, 1'b1, 8'd0, 11'd0, 10'd0, 16'd0});
    chk("reset_outputs_small", {vde_s, hsync_s, vsync_s, red_s}, {1'b0, 1'b1, 1'b1, 8'd0});

    rst = 1'b0;
    run_cycles(12300, 1'b1);
    chk("table_consumed", 64'(vi), 64'(vecs.size()));
    chk("pre_reset_state", {x, y, vde, red}, {11'd300, 10'd3, 1'b1, 8'd41});

    // Mid-line asynchronous reset: outputs must drop without waiting for a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("async_reset_main", {vde, hsync, vsync, red, green, blue, x, y, frame_count},
        {1'b0, 1'b1, 1'b1, 24'd0, 11'd0, 10'd0, 16'd0});
    chk("async_reset_small", {vde_s, hsync_s, vsync_s, red_s, x_s},
        {1'b0, 1'b1, 1'b1, 8'd0, 11'd0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_reset_sync", {hsync, vsync, vde, x}, {1'b1, 1'b1, 1'b0, 11'd0});
    end

    restart_state();
    rst = 1'b0;
    chk("restart_first_cycle", {x, y, frame_start, line_start, frame_count},
        {11'd0, 10'd0, 1'b1, 1'b1, 16'd0});
    run_cycles(900, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
